// File: rtl/shared_round_key_buffer.sv
// shared_round_key_buffer: captures both shares of each expanded round key and serves them by index with one-cycle latency
// Ports: kx_* fill stream from the key expansion (key0/key1 shares, round index, occupied);
//        rk_req/rk_idx read request -> rk_valid/rk_q0/rk_q1/rk_idx_err one cycle later;
//        buf_ready = full key set stored, fill_err = sticky incomplete-fill flag.
// Optional macro RK_REMASK_EN: adds rk_rnd, XORed into both shares of every valid read.
module shared_round_key_buffer #(
  parameter int KW = 128,
  parameter int CW = 5,
  parameter int NKEYS = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [KW-1:0] kx_key0,
  input  logic [KW-1:0] kx_key1,
  input  logic [CW-1:0] kx_round_cnt,
  input  logic          kx_occupied,
  input  logic          rk_req,
  input  logic [CW-1:0] rk_idx,
`ifdef RK_REMASK_EN
  input  logic [KW-1:0] rk_rnd,
`endif
  output logic          rk_valid,
  output logic [KW-1:0] rk_q0,
  output logic [KW-1:0] rk_q1,
  output logic          rk_idx_err,
  output logic          buf_ready,
  output logic          fill_err
);
  typedef enum logic [1:0] {EMPTY, FILL, READY} state_t;
  localparam logic [CW-1:0] NK = CW'(NKEYS);
  state_t state;
  logic [KW-1:0] mem0 [NKEYS];
  logic [KW-1:0] mem1 [NKEYS];
  logic [NKEYS-1:0] mask, mask_nxt;
  logic [KW-1:0] rm;
  logic entry, wr, rd, idx_ok;
`ifdef RK_REMASK_EN
  assign rm = rk_rnd;
`else
  assign rm = '0;
`endif
  // Any occupied cycle outside FILL is a fill entry; it wins over a same-cycle read.
  always_comb begin
    entry = kx_occupied && state != FILL;
    wr = kx_occupied && kx_round_cnt < NK;
    rd = state == READY && rk_req && !kx_occupied;
    idx_ok = rk_idx < NK;
    mask_nxt = (entry ? '0 : mask) | (wr ? NKEYS'(1) << kx_round_cnt : '0);
  end
  // Key storage is deliberately unreset; the mask alone tracks validity.
  always_ff @(posedge clk)
    if (wr && !rst) begin
      mem0[kx_round_cnt] <= kx_key0;
      mem1[kx_round_cnt] <= kx_key1;
    end
  // Separate read muxes and output registers per share; the same fresh mask goes onto both.
  always_ff @(posedge clk)
    if (rst) begin
      state <= EMPTY;
      mask <= '0;
      buf_ready <= 1'b0;
      fill_err <= 1'b0;
      rk_valid <= 1'b0;
      rk_idx_err <= 1'b0;
      rk_q0 <= '0;
      rk_q1 <= '0;
    end else begin
      mask <= mask_nxt;
      rk_valid <= rd;
      rk_idx_err <= rd && !idx_ok;
      if (rd) begin
        rk_q0 <= idx_ok ? mem0[rk_idx] ^ rm : '0;
        rk_q1 <= idx_ok ? mem1[rk_idx] ^ rm : '0;
      end
      if (entry) begin
        state <= FILL;
        buf_ready <= 1'b0;
        fill_err <= 1'b0;
      end else if (state == FILL && !kx_occupied) begin
        state <= &mask ? READY : EMPTY;
        buf_ready <= &mask;
        fill_err <= ~&mask;
      end
    end
endmodule

// File: tb/tb_shared_round_key_buffer.sv
// tb_shared_round_key_buffer: scoreboard bench for the shared round-key buffer
module tb_shared_round_key_buffer;
  logic clk = 1'b0, rst = 1'b0;
  logic [127:0] kx_key0 = '0, kx_key1 = '0, rk_rnd = {16{8'hA5}}, rk_q0, rk_q1;
  logic [4:0] kx_round_cnt = '0, rk_idx = '0;
  logic kx_occupied = 1'b0, rk_req = 1'b0, rk_valid, rk_idx_err, buf_ready, fill_err;
  logic [127:0] ref0 [17];
  logic [127:0] ref1 [17];
  logic [127:0] msk;
  typedef struct packed {logic err; logic [127:0] q0; logic [127:0] q1;} exp_t;
  exp_t sb[$];
  exp_t e;
  int compared = 0, mismatched = 0;

  shared_round_key_buffer dut (
    .clk(clk), .rst(rst), .kx_key0(kx_key0), .kx_key1(kx_key1),
    .kx_round_cnt(kx_round_cnt), .kx_occupied(kx_occupied),
    .rk_req(rk_req), .rk_idx(rk_idx),
`ifdef RK_REMASK_EN
    .rk_rnd(rk_rnd),
`endif
    .rk_valid(rk_valid), .rk_q0(rk_q0), .rk_q1(rk_q1),
    .rk_idx_err(rk_idx_err), .buf_ready(buf_ready), .fill_err(fill_err));

  always #5 clk = ~clk;

`ifdef RK_REMASK_EN
  assign msk = rk_rnd;
`else
  assign msk = '0;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int first, input int last, input logic [127:0] k1, input int rst_at);
    for (int i = first; i <= last; i++) begin
      kx_occupied = 1'b1;
      if (i == rst_at) rst = 1'b1;
      else begin
        kx_round_cnt = 5'(i);
        kx_key0 = {32{4'(i)}};
        kx_key1 = k1;
        if (i < 17) begin
          ref0[i] = kx_key0;
          ref1[i] = k1;
        end
      end
      tick;
      if (i == rst_at) begin
        rst = 1'b0;
        kx_occupied = 1'b0;
        return;
      end
      if (i == first) begin
        compared++;
        if (fill_err !== 1'b0 || buf_ready !== 1'b0) begin
          mismatched++;
          $display("FAIL fill_entry: fill_err=%b buf_ready=%b, need 0/0", fill_err, buf_ready);
        end
      end
    end
    kx_occupied = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    compared++;
    if ({rk_valid, rk_idx_err, buf_ready, fill_err} !== 4'b0 || rk_q0 !== '0 || rk_q1 !== '0) begin
      mismatched++;
      $display("FAIL reset: v=%b e=%b rdy=%b ferr=%b q0=%h q1=%h, need all 0", rk_valid, rk_idx_err, buf_ready, fill_err, rk_q0, rk_q1);
    end
    rk_req = 1'b1;
    rk_idx = 5'd1;
    tick;
    rk_req = 1'b0;
    compared++;
    if (rk_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL empty_read: rk_valid=%b, need 0", rk_valid);
    end
  endtask

  task automatic test_fill_read;
    fill(0, 16, '0, -1);
    compared++;
    if (buf_ready !== 1'b1 || fill_err !== 1'b0) begin
      mismatched++;
      $display("FAIL fill_ready: buf_ready=%b fill_err=%b, need 1/0", buf_ready, fill_err);
    end
    rk_req = 1'b1;
    rk_idx = 5'd5;
    sb.push_back('{1'b0, ref0[5] ^ msk, ref1[5] ^ msk});
    tick;
    rk_req = 1'b0;
    e = sb.pop_front();
    compared++;
    if (rk_valid !== 1'b1 || rk_idx_err !== e.err || rk_q0 !== e.q0 || rk_q1 !== e.q1) begin
      mismatched++;
      $display("FAIL read5: v=%b e=%b q0=%h q1=%h, need 1 %b %h %h", rk_valid, rk_idx_err, rk_q0, rk_q1, e.err, e.q0, e.q1);
    end
    compared++;
    if ((rk_q0 ^ rk_q1) !== {32{4'h5}}) begin
      mismatched++;
      $display("FAIL read5_unshared: got %h need %h", rk_q0 ^ rk_q1, {32{4'h5}});
    end
    tick;
    compared++;
    if (rk_valid !== 1'b0 || rk_q0 !== e.q0) begin
      mismatched++;
      $display("FAIL read_hold: v=%b q0=%h, need 0 %h", rk_valid, rk_q0, e.q0);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] n;
    fill(0, 16, '1, -1);
    rk_req = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rk_idx = 5'(i);
      n = 4'(i);
      sb.push_back('{1'b0, ref0[i] ^ msk, ref1[i] ^ msk});
      tick;
      e = sb.pop_front();
      compared++;
      if (rk_valid !== 1'b1 || rk_idx_err !== e.err || rk_q0 !== e.q0 || rk_q1 !== e.q1) begin
        mismatched++;
        $display("FAIL b2b_%0d: v=%b e=%b q0=%h q1=%h, need 1 %b %h %h", i, rk_valid, rk_idx_err, rk_q0, rk_q1, e.err, e.q0, e.q1);
      end
      compared++;
      if ((rk_q0 ^ rk_q1) !== ~{32{n}}) begin
        mismatched++;
        $display("FAIL b2b_unshared_%0d: got %h need %h", i, rk_q0 ^ rk_q1, ~{32{n}});
      end
    end
    rk_req = 1'b0;
    tick;
    compared++;
    if (rk_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_end: rk_valid=%b, need 0", rk_valid);
    end
  endtask

  task automatic test_idx_err;
    rk_req = 1'b1;
    rk_idx = 5'd17;
    sb.push_back('{1'b1, 128'h0, 128'h0});
    tick;
    rk_req = 1'b0;
    e = sb.pop_front();
    compared++;
    if (rk_valid !== 1'b1 || rk_idx_err !== e.err || rk_q0 !== e.q0 || rk_q1 !== e.q1) begin
      mismatched++;
      $display("FAIL idx_err: v=%b e=%b q0=%h q1=%h, need 1 1 0 0", rk_valid, rk_idx_err, rk_q0, rk_q1);
    end
    rk_req = 1'b1;
    rk_idx = 5'd3;
    kx_occupied = 1'b1;
    kx_round_cnt = 5'd0;
    kx_key0 = '0;
    kx_key1 = '0;
    ref0[0] = '0;
    ref1[0] = '0;
    tick;
    rk_req = 1'b0;
    compared++;
    if (rk_valid !== 1'b0 || rk_idx_err !== 1'b0 || buf_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL read_vs_fill: v=%b e=%b rdy=%b, need 0 0 0", rk_valid, rk_idx_err, buf_ready);
    end
    fill(1, 17, '0, -1);
    compared++;
    if (buf_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL refill_ready: buf_ready=%b, need 1", buf_ready);
    end
  endtask

  task automatic test_partial_fill;
    fill(0, 9, '0, -1);
    compared++;
    if (fill_err !== 1'b1 || buf_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL partial: fill_err=%b buf_ready=%b, need 1/0", fill_err, buf_ready);
    end
    rk_req = 1'b1;
    rk_idx = 5'd3;
    tick;
    rk_req = 1'b0;
    compared++;
    if (rk_valid !== 1'b0 || fill_err !== 1'b1) begin
      mismatched++;
      $display("FAIL partial_read: v=%b fill_err=%b, need 0/1", rk_valid, fill_err);
    end
  endtask

  task automatic test_reset_mid_fill;
    fill(0, 16, '0, 8);
    tick;
    tick;
    compared++;
    if (fill_err !== 1'b0 || buf_ready !== 1'b0 || rk_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_fill: fill_err=%b buf_ready=%b v=%b, need 0 0 0", fill_err, buf_ready, rk_valid);
    end
    fill(0, 16, '0, -1);
    compared++;
    if (buf_ready !== 1'b1 || fill_err !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_refill: buf_ready=%b fill_err=%b, need 1/0", buf_ready, fill_err);
    end
  endtask

  task automatic test_remask;
    rk_req = 1'b1;
    rk_idx = 5'd2;
    sb.push_back('{1'b0, ref0[2] ^ msk, ref1[2] ^ msk});
    tick;
    rk_req = 1'b0;
    e = sb.pop_front();
    compared++;
    if (rk_valid !== 1'b1 || rk_q0 !== e.q0 || rk_q1 !== e.q1) begin
      mismatched++;
      $display("FAIL remask: v=%b q0=%h q1=%h, need 1 %h %h", rk_valid, rk_q0, rk_q1, e.q0, e.q1);
    end
`ifdef RK_REMASK_EN
    compared++;
    if (rk_q0 !== {16{8'h87}} || rk_q1 !== {16{8'hA5}}) begin
      mismatched++;
      $display("FAIL remask_const: q0=%h q1=%h, need 8787.. a5a5..", rk_q0, rk_q1);
    end
`endif
    compared++;
    if ((rk_q0 ^ rk_q1) !== {32{4'h2}}) begin
      mismatched++;
      $display("FAIL remask_unshared: got %h need %h", rk_q0 ^ rk_q1, {32{4'h2}});
    end
  endtask

  initial begin
    test_reset;
    test_fill_read;
    test_back_to_back;
    test_idx_err;
    test_partial_fill;
    test_reset_mid_fill;
    test_remask;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
